// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the bit-serial adder
// Purpose: FSM state encoding and counter-width helper used by serial_adder.
// Ports: none (package).
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must reach WIDTH after the final increment, hence WIDTH+1 values.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// rtl/serial_adder_fa_cell.sv - combinational full adder from two half-adder stages
// Purpose: one-bit full adder; first half adder combines a_i/b_i, second adds cin_i,
//          carry-out is the OR of the two half-adder carries.
// Ports:
//   a_i, b_i  operand bits
//   cin_i     carry in
//   s_o       sum bit
//   cout_o    carry out
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    logic p1;
    logic g1;
    logic g2;

    // Stage 1 half adder.
    assign p1 = a_i ^ b_i;
    assign g1 = a_i & b_i;

    // Stage 2 half adder.
    assign s_o = p1 ^ cin_i;
    assign g2  = p1 & cin_i;

    // The two carries can never both be 1, so OR equals majority here.
    assign cout_o = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one bit per clock, LSB first
// Purpose: captures a, b, cin on an accepted start, adds one bit per cycle through a
//          single full-adder cell and a carry flop, then publishes {cout,sum} with a
//          one-cycle done pulse.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only in IDLE or DONE
//   a, b   WIDTH-bit operands, cin carry-in (captured on accepted start)
//   busy   high while computing
//   done   one-cycle result-valid pulse
//   sum    registered WIDTH-bit result, cout registered carry-out
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] ps_shift;

    fa_cell u_fa (
        .a_i    (sh_a_q[0]),
        .b_i    (sh_b_q[0]),
        .cin_i  (c_q),
        .s_o    (fa_s),
        .cout_o (fa_co)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_ps_one
            assign ps_shift = fa_s;
        end else begin : g_ps_wide
            assign ps_shift = {fa_s, ps_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        ps_d    = ps_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    sh_a_d  = a;
                    sh_b_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    ps_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sh_a_d = sh_a_q >> 1;
                sh_b_d = sh_b_q >> 1;
                c_d    = fa_co;
                ps_d   = ps_shift;
                cnt_d  = cnt_q + CW'(1);
                // Outputs update only here, so partial sums are never visible.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = ps_shift;
                    cout_d  = fa_co;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            ps_q    <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            ps_q    <= ps_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    // WIDTH=1 instance
    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition, 9-bit result.
    function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int r;
        r = int'(x) + int'(y) + int'(c);
        return r[8:0];
    endfunction

    // One WIDTH=8 operation; checks result, latency, busy length, held output, single pulse.
    task automatic op8(input string name, input logic [7:0] x, input logic [7:0] y,
                       input logic c, input logic [7:0] exp_s, input logic exp_co,
                       input bit toggle);
        logic [7:0] prev_s;
        logic       prev_c;
        int         lat;
        int         bcnt;
        bit         held_ok;
        @(negedge clk);
        prev_s  = sum8;
        prev_c  = cout8;
        held_ok = 1'b1;
        a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        lat  = -1;
        bcnt = busy8 ? 1 : 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) begin
                lat = k;
                break;
            end
            if (busy8) bcnt++;
            if (sum8 !== prev_s || cout8 !== prev_c) held_ok = 1'b0;
            if (toggle) begin
                start8 = k[0];
                a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
            end
        end
        start8 = 1'b0;
        chk({name, " latency"}, lat, 8);
        chk({name, " busy_cycles"}, bcnt, 8);
        chk({name, " held"}, held_ok, 1);
        chk({name, " sum"}, sum8, exp_s);
        chk({name, " cout"}, cout8, exp_co);
        @(negedge clk);
        chk({name, " done_single"}, done8, 0);
        chk({name, " busy_after"}, busy8, 0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        bit         toggle;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] r9;
        logic [7:0] ra, rb;
        logic       rc;
        logic [7:0] bb_a[3];
        logic [7:0] bb_b[3];
        logic       bb_c[3];
        int         times[3];
        int         idx;
        int         cyc;
        int         ndone;
        int         lat1;
        int         exp1;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy", busy8, 0);
        chk("reset done", done8, 0);
        chk("reset sum", sum8, 0);
        chk("reset cout", cout8, 0);
        chk("reset w1 sum", {cout1, sum1}, 0);

        // Directed table
        foreach (tbl[i]) begin
            op8($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
                tbl[i].s, tbl[i].co, tbl[i].toggle);
        end

        // Randomized against integer model
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            r9 = ref_add8(ra, rb, rc);
            op8($sformatf("rnd%0d", i), ra, rb, rc, r9[7:0], r9[8], bit'($urandom_range(0, 1)));
        end

        // Back-to-back: start held high, new operands presented in each DONE cycle
        bb_a[0] = 8'h12; bb_b[0] = 8'h34; bb_c[0] = 1'b1;
        bb_a[1] = 8'hF0; bb_b[1] = 8'h0F; bb_c[1] = 1'b1;
        bb_a[2] = 8'hC3; bb_b[2] = 8'h7E; bb_c[2] = 1'b0;
        @(negedge clk);
        a8 = bb_a[0]; b8 = bb_b[0]; cin8 = bb_c[0]; start8 = 1'b1;
        idx = 0;
        cyc = 0;
        for (int t = 0; t < 60 && idx < 3; t++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done8) begin
                r9 = ref_add8(bb_a[idx], bb_b[idx], bb_c[idx]);
                chk($sformatf("b2b%0d result", idx), {cout8, sum8}, r9);
                times[idx] = cyc;
                idx++;
                if (idx < 3) begin
                    a8 = bb_a[idx]; b8 = bb_b[idx]; cin8 = bb_c[idx];
                end else begin
                    start8 = 1'b0;
                end
            end
        end
        start8 = 1'b0;
        chk("b2b count", idx, 3);
        if (idx == 3) begin
            chk("b2b first", times[0], 9);
            chk("b2b gap1", times[1] - times[0], 9);
            chk("b2b gap2", times[2] - times[1], 9);
        end

        // Reset during the 4th RUN cycle
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst busy", busy8, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst busy", busy8, 0);
        chk("rst done", done8, 0);
        chk("rst sum", sum8, 0);
        chk("rst cout", cout8, 0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("rst no_done", ndone, 0);
        op8("post_rst", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

        // WIDTH=1 exhaustive
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            a1 = v[0]; b1 = v[1]; cin1 = v[2]; start1 = 1'b1;
            exp1 = int'(v[0]) + int'(v[1]) + int'(v[2]);
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            chk($sformatf("w1_%0d busy", v), busy1, 1);
            lat1 = -1;
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (done1) begin
                    lat1 = k;
                    break;
                end
            end
            chk($sformatf("w1_%0d latency", v), lat1, 1);
            chk($sformatf("w1_%0d result", v), {cout1, sum1}, exp1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
